// File: rtl/data_mem_responder.sv
// Responder side of the CPU data-memory interface: a word-addressed synchronous RAM
// behind an IDLE/WAIT/RESP handshake with programmable wait states and access checking.
module data_mem_responder #(
  parameter int          DEPTH_WORDS = 256,
  parameter int          WAIT_STATES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] data_address,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        mem_ready,
  output logic        addr_err
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WS_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  state_e          state_q;
  logic [3:0]      cnt_q;
  logic            rd_q, wr_q, err_q;
  logic [AW-1:0]   idx_q;
  logic [31:0]     wdata_q;
  logic [31:0]     dout_q;
  logic            ready_q, aerr_q;
  logic [31:0]     mem [DEPTH_WORDS];

  // Accept-time decode of the live request
  logic            req;
  logic [31:0]     off;
  logic            err_in;
  logic [AW-1:0]   idx_in;

  assign req    = mem_read | mem_write;
  assign off    = data_address - BASE_ADDR;
  assign err_in = (data_address[1:0] != 2'b00) | (data_address < BASE_ADDR) |
                  ((off >> 2) >= 32'(DEPTH_WORDS)) | (mem_read & mem_write);
  assign idx_in = off[AW+1:2];

  // Operation committed on the edge that enters RESP; with no wait states the
  // live request goes straight through, otherwise the latched copy is used.
  logic            go_resp;
  logic            c_rd, c_wr, c_err;
  logic [AW-1:0]   c_idx;
  logic [31:0]     c_wdata;

  always_comb begin
    go_resp = 1'b0;
    c_rd    = rd_q;
    c_wr    = wr_q;
    c_err   = err_q;
    c_idx   = idx_q;
    c_wdata = wdata_q;
    if (state_q == S_IDLE && req && WAIT_STATES == 0) begin
      go_resp = 1'b1;
      c_rd    = mem_read;
      c_wr    = mem_write;
      c_err   = err_in;
      c_idx   = idx_in;
      c_wdata = data_in;
    end else if (state_q == S_WAIT && cnt_q == 4'd0) begin
      go_resp = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      idx_q   <= '0;
      wdata_q <= 32'd0;
      ready_q <= 1'b0;
      aerr_q  <= 1'b0;
      dout_q  <= 32'd0;
    end else begin
      case (state_q)
        S_IDLE: if (req) begin
          rd_q    <= mem_read;
          wr_q    <= mem_write;
          err_q   <= err_in;
          idx_q   <= idx_in;
          wdata_q <= data_in;
          if (WAIT_STATES > 0) begin
            state_q <= S_WAIT;
            cnt_q   <= WS_INIT;
          end else begin
            state_q <= S_RESP;
          end
        end
        S_WAIT: if (cnt_q == 4'd0) state_q <= S_RESP;
                else cnt_q <= cnt_q - 4'd1;
        S_RESP: state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
      ready_q <= go_resp;
      aerr_q  <= go_resp & c_err;
      if (go_resp) begin
        if (c_err)     dout_q <= 32'd0;
        else if (c_rd) dout_q <= mem[c_idx];
      end
    end
  end

  // RAM is not reset; a reset on the commit edge suppresses the write
  always_ff @(posedge clk) begin
    if (rst && go_resp && c_wr && !c_err) mem[c_idx] <= c_wdata;
  end

  assign data_out  = dout_q;
  assign mem_ready = ready_q;
  assign addr_err  = aerr_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench: four responders with different wait-state/base settings, each
// driven by its own request lines; expected values are hand-computed constants.
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        rstn [4];
  logic        rd   [4];
  logic        wr   [4];
  logic [31:0] addr [4];
  logic [31:0] din  [4];
  logic [31:0] dout [4];
  logic        rdy  [4];
  logic        aerr [4];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(1), .BASE_ADDR(32'h0)) u0 (
    .clk(clk), .rst(rstn[0]), .mem_read(rd[0]), .mem_write(wr[0]), .data_address(addr[0]),
    .data_in(din[0]), .data_out(dout[0]), .mem_ready(rdy[0]), .addr_err(aerr[0]));
  data_mem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(0), .BASE_ADDR(32'h0)) u1 (
    .clk(clk), .rst(rstn[1]), .mem_read(rd[1]), .mem_write(wr[1]), .data_address(addr[1]),
    .data_in(din[1]), .data_out(dout[1]), .mem_ready(rdy[1]), .addr_err(aerr[1]));
  data_mem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(3), .BASE_ADDR(32'h0)) u2 (
    .clk(clk), .rst(rstn[2]), .mem_read(rd[2]), .mem_write(wr[2]), .data_address(addr[2]),
    .data_in(din[2]), .data_out(dout[2]), .mem_ready(rdy[2]), .addr_err(aerr[2]));
  data_mem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(1), .BASE_ADDR(32'h1000)) u3 (
    .clk(clk), .rst(rstn[3]), .mem_read(rd[3]), .mem_write(wr[3]), .data_address(addr[3]),
    .data_in(din[3]), .data_out(dout[3]), .mem_ready(rdy[3]), .addr_err(aerr[3]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Issue one request on instance i; checks latency, ready width and the response.
  task automatic access(input int i, input bit r, input bit w, input logic [31:0] a,
                        input logic [31:0] d, input int exp_lat, input bit hold,
                        output logic [31:0] dat, output logic e);
    int n;
    @(negedge clk);
    rd[i] = r; wr[i] = w; addr[i] = a; din[i] = d;
    n = 0;
    dat = 32'hx; e = 1'bx;
    while (n < 40) begin
      @(posedge clk); #1;
      n++;
      if (n == 1 && !hold) begin rd[i] = 1'b0; wr[i] = 1'b0; addr[i] = 32'hFFFF_FFFF; end
      if (rdy[i]) break;
    end
    chk($sformatf("lat u%0d @%h", i, a), n, exp_lat);
    dat = dout[i];
    e   = aerr[i];
    rd[i] = 1'b0; wr[i] = 1'b0;
    @(posedge clk); #1;
    chk($sformatf("rdy_drop u%0d", i), {31'd0, rdy[i]}, 32'd0);
  endtask

  logic [31:0] dat;
  logic        e;

  initial begin
    for (int i = 0; i < 4; i++) begin
      rstn[i] = 1'b0; rd[i] = 1'b0; wr[i] = 1'b0; addr[i] = 32'd0; din[i] = 32'd0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rst rdy u%0d", i), {31'd0, rdy[i]}, 32'd0);
      chk($sformatf("rst err u%0d", i), {31'd0, aerr[i]}, 32'd0);
      chk($sformatf("rst dout u%0d", i), dout[i], 32'd0);
    end
    @(negedge clk);
    for (int i = 0; i < 4; i++) rstn[i] = 1'b1;

    // Write then read back with one wait state
    access(0, 1, 0, 32'h10, 32'h0, 2, 1, dat, e);
    access(0, 0, 1, 32'h10, 32'hDEAD_BEEF, 2, 1, dat, e);
    chk("wr err", {31'd0, e}, 32'd0);
    access(0, 1, 0, 32'h10, 32'h0, 2, 1, dat, e);
    chk("rd err", {31'd0, e}, 32'd0);
    chk("rd data", dat, 32'hDEAD_BEEF);

    // Misaligned and out-of-range reads leave RAM alone
    access(0, 0, 1, 32'h0,   32'h1111_1111, 2, 1, dat, e);
    access(0, 0, 1, 32'h3FC, 32'h2222_2222, 2, 1, dat, e);
    access(0, 1, 0, 32'h3FC, 32'h0, 2, 1, dat, e);
    chk("rd top word", dat, 32'h2222_2222);
    access(0, 1, 0, 32'h13, 32'h0, 2, 1, dat, e);
    chk("misalign err", {31'd0, e}, 32'd1);
    chk("misalign dout", dat, 32'd0);
    access(0, 1, 0, 32'h3FC, 32'h0, 2, 1, dat, e);
    access(0, 1, 0, 32'h400, 32'h0, 2, 1, dat, e);
    chk("range err", {31'd0, e}, 32'd1);
    chk("range dout", dat, 32'd0);
    access(0, 0, 1, 32'h400, 32'h9999_9999, 2, 1, dat, e);
    chk("range wr err", {31'd0, e}, 32'd1);
    access(0, 1, 0, 32'h0, 32'h0, 2, 1, dat, e);
    chk("word0 kept", dat, 32'h1111_1111);
    access(0, 1, 0, 32'h3FC, 32'h0, 2, 1, dat, e);
    chk("wordFF kept", dat, 32'h2222_2222);

    // Simultaneous read+write is rejected and does not write
    access(0, 0, 1, 32'h8, 32'h55, 2, 1, dat, e);
    access(0, 1, 1, 32'h8, 32'h1, 2, 1, dat, e);
    chk("rdwr err", {31'd0, e}, 32'd1);
    chk("rdwr dout", dat, 32'd0);
    access(0, 1, 0, 32'h8, 32'h0, 2, 1, dat, e);
    chk("rdwr kept", dat, 32'h55);
    chk("rdwr kept err", {31'd0, e}, 32'd0);

    // Zero wait states: held read responds every second cycle
    access(1, 0, 1, 32'h4, 32'h0000_1234, 1, 1, dat, e);
    @(negedge clk);
    rd[1] = 1'b1; addr[1] = 32'h4;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      chk($sformatf("burst rdy %0d", k), {31'd0, rdy[1]}, (k % 2 == 0) ? 32'd1 : 32'd0);
      if (k % 2 == 0) chk($sformatf("burst data %0d", k), dout[1], 32'h0000_1234);
    end
    rd[1] = 1'b0;
    @(posedge clk); #1;

    // Three wait states: drop request mid-WAIT, then abort a write with reset
    access(2, 0, 1, 32'h20, 32'h0000_0077, 4, 0, dat, e);
    access(2, 1, 0, 32'h20, 32'h0, 4, 0, dat, e);
    chk("drop rd data", dat, 32'h0000_0077);
    @(negedge clk);
    wr[2] = 1'b1; addr[2] = 32'h20; din[2] = 32'hA5A5_A5A5;
    @(posedge clk); #1;
    wr[2] = 1'b0;
    @(negedge clk);
    rstn[2] = 1'b0;
    @(posedge clk); #1;
    chk("abort rdy", {31'd0, rdy[2]}, 32'd0);
    chk("abort err", {31'd0, aerr[2]}, 32'd0);
    chk("abort dout", dout[2], 32'd0);
    @(negedge clk);
    rstn[2] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk($sformatf("abort idle %0d", k), {31'd0, rdy[2]}, 32'd0);
    end
    access(2, 1, 0, 32'h20, 32'h0, 4, 1, dat, e);
    chk("abort kept", dat, 32'h0000_0077);

    // Non-zero base address
    access(3, 0, 1, 32'h1000, 32'hCAFE_F00D, 2, 1, dat, e);
    access(3, 1, 0, 32'h0, 32'h0, 2, 1, dat, e);
    chk("base low err", {31'd0, e}, 32'd1);
    access(3, 1, 0, 32'h1000, 32'h0, 2, 1, dat, e);
    chk("base rd err", {31'd0, e}, 32'd0);
    chk("base rd data", dat, 32'hCAFE_F00D);
    access(3, 1, 0, 32'h1400, 32'h0, 2, 1, dat, e);
    chk("base high err", {31'd0, e}, 32'd1);
    access(3, 0, 1, 32'h13FC, 32'h0BAD_CAFE, 2, 1, dat, e);
    chk("base top err", {31'd0, e}, 32'd0);
    access(3, 1, 0, 32'h13FC, 32'h0, 2, 1, dat, e);
    chk("base top data", dat, 32'h0BAD_CAFE);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
